// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider that owns the HI/LO pair.
// Optional MULDIV_ABORT_EN adds an abort input that cancels a running op.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lw_q, lw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             abort_w;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, shifted, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef MULDIV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign abs_a = (op[0] && A[WIDTH-1]) ? -A : A;
  assign abs_b = (op[0] && B[WIDTH-1]) ? -B : B;

  // acc holds the upper product half / partial remainder, lw the lower half / quotient
  assign mul_sum = {1'b0, acc_q} + (lw_q[0] ? {1'b0, m_q} : '0);
  assign shifted = {acc_q, lw_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, m_q};

  assign prod     = {acc_q, lw_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = neg_res_q ? -lw_q : lw_q;
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    m_d       = m_q;
    acc_d     = acc_q;
    lw_d      = lw_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          is_div_d  = op[1];
          neg_res_d = op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem_d = op[0] & op[1] & A[WIDTH-1];
          m_d       = op[1] ? abs_b : abs_a;
          lw_d      = op[1] ? abs_a : abs_b;
          acc_d     = '0;
          cnt_d     = '0;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            lw_d  = {lw_q[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            lw_d  = {mul_sum[0], lw_q[WIDTH-1:1]};
          end
          if (cnt_q == LAST) state_d = S_FIX;
          else cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      m_q       <= '0;
      acc_q     <= '0;
      lw_q      <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      lw_q      <= lw_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: fixed vectors, corner sequences, random ops vs a model.
// Abort sequence is exercised when MULDIV_ABORT_EN is defined.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_r = 2'd0;
  logic [31:0] a_r = '0;
  logic [31:0] b_r = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
`ifdef MULDIV_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_r),
    .A(a_r), .B(b_r), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
`ifdef MULDIV_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    string       nm;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Architectural result of one operation, from arithmetic on the operand values.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32]; l = up[31:0];
      end
      2'd1: begin
        p = sa * sb;
        h = p[63:32]; l = p[31:0];
      end
      2'd2: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      default: begin
        if (b == 0) begin
          l = a[31] ? 32'd1 : 32'hFFFF_FFFF; h = a;
        end else begin
          q = sa / sb; r = sa % sb;
          l = q[31:0]; h = r[31:0];
        end
      end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string nm,
                       input int inj, input bit wr_start, input bit done_wr);
    int cyc;
    int bcnt;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; op_r = o; a_r = a; b_r = b;
    if (wr_start) begin
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h99;
    end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a_r = $urandom; b_r = $urandom;
    cyc = 0; bcnt = 0; seen = 0;
    while (!seen && cyc < 100) begin
      if (cyc == inj) begin
        start = 1'b1; op_r = ~o; hi_we = 1'b1; wdata = 32'h1234;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) begin
        chk({nm, " hold_hi"}, hi, m_hi);
        chk({nm, " hold_lo"}, lo, m_lo);
      end
      if (done) begin
        seen = 1;
      end else begin
        if (busy) bcnt++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0; hi_we = 1'b0;
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    chk({nm, " busy_cycles"}, 32'(bcnt), 32'd33);
    chk({nm, " busy_in_done"}, 32'(busy), 32'd0);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    m_hi = eh; m_lo = el;
    if (done_wr) begin
      lo_we = 1'b1; wdata = 32'hD0E; m_lo = 32'hD0E;
    end
    @(posedge clk); #1;
    lo_we = 1'b0;
    @(negedge clk);
    chk({nm, " done_once"}, 32'(done), 32'd0);
    chk({nm, " idle_busy"}, 32'(busy), 32'd0);
    chk({nm, " after_hi"}, hi, m_hi);
    chk({nm, " after_lo"}, lo, m_lo);
  endtask

  initial begin
    logic [31:0] ra, rb, eh, el;
    logic [1:0]  ro;

    vt[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vt[1]  = '{2'd1, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m7x3"};
    vt[2]  = '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"};
    vt[3]  = '{2'd2, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by0"};
    vt[4]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf"};
    vt[5]  = '{2'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'd1,         "div_neg_by0"};
    vt[6]  = '{2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "div_pos_by0"};
    vt[7]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100d7"};
    vt[8]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7dm2"};
    vt[9]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         "mult_min_sq"};
    vt[10] = '{2'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         32'h8000_0000, "mult_m1xmin"};
    vt[11] = '{2'd0, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         "multu_zero"};

    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 12; i++)
      do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, vt[i].nm,
            (i == 1) ? 5 : -1, (i == 2), (i == 3));

    // MTLO alone, then MTHI+MTLO together, in IDLE
    @(posedge clk); #1;
    lo_we = 1'b1; wdata = 32'h55;
    @(posedge clk); #1;
    lo_we = 1'b0;
    @(negedge clk);
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_hi_kept", hi, m_hi);
    @(posedge clk); #1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    chk("mt_both_hi", hi, 32'hCAFE);
    chk("mt_both_lo", lo, 32'hCAFE);
    m_hi = 32'hCAFE; m_lo = 32'hCAFE;

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      ref_op(ro, ra, rb, eh, el);
      do_op(ro, ra, rb, eh, el, "rnd", -1, 1'b0, 1'b0);
    end

    // asynchronous reset in the middle of CALC
    @(posedge clk); #1;
    start = 1'b1; op_r = 2'd0; a_r = 32'd3; b_r = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef MULDIV_ABORT_EN
    begin
      int dcnt;
      @(posedge clk); #1;
      hi_we = 1'b1; wdata = 32'hAA;
      @(posedge clk); #1;
      hi_we = 1'b0; m_hi = 32'hAA;
      start = 1'b1; op_r = 2'd0; a_r = 32'd3; b_r = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hi", hi, 32'hAA);
      chk("abort_lo", lo, m_lo);
      dcnt = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) dcnt++;
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);
      do_op(2'd0, 32'd3, 32'd5, 32'd0, 32'd15, "post_abort", -1, 1'b0, 1'b0);
    end
`endif

    do_op(2'd0, 32'd3, 32'd5, 32'd0, 32'd15, "post_rst", -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
